wdog_period_monitor: RTL and testbench



---
 rtl/wdog_period_monitor_if.sv | 21 ++
 rtl/wdog_period_monitor.sv | 118 +++++++++++
 tb/tb_wdog_period_monitor.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/wdog_period_monitor_if.sv
// rtl/wdog_period_monitor_if.sv - host-side port bundle for the watchdog period monitor
interface wdog_period_monitor_if;
  logic        period_wr;
  logic [15:0] period_in;
  logic        wdog_refresh;
  logic        timeout_clr;
  logic [2:0]  wdog_period_status;
  logic        wdog_timeout_led;
  logic        wdog_timeout_pulse;
  logic [15:0] wdog_count;

  modport master (
    output period_wr, period_in, wdog_refresh, timeout_clr,
    input  wdog_period_status, wdog_timeout_led, wdog_timeout_pulse, wdog_count
  );

  modport slave (
    input  period_wr, period_in, wdog_refresh, timeout_clr,
    output wdog_period_status, wdog_timeout_led, wdog_timeout_pulse, wdog_count
  );
endinterface

// File: rtl/wdog_period_monitor.sv
// rtl/wdog_period_monitor.sv - watchdog period register, tick prescaler, timeout latch
module wdog_period_monitor #(
  parameter int TICK_DIV = 3072,
  parameter int TH1      = 1600,
  parameter int TH2      = 4800,
  parameter int TH3      = 16000
) (
  input  logic                   sysclk,
  input  logic                   reset,
  wdog_period_monitor_if.slave   bus
);
  localparam int PW = $clog2(TICK_DIV);

  localparam logic [2:0] WDOG_DISABLE     = 3'd0;
  localparam logic [2:0] WDOG_PHASE_ONE   = 3'd1;
  localparam logic [2:0] WDOG_PHASE_TWO   = 3'd2;
  localparam logic [2:0] WDOG_PHASE_THREE = 3'd3;
  localparam logic [2:0] WDOG_PHASE_FOUR  = 3'd4;

  typedef enum logic [1:0] {IDLE, ARMED, EXPIRED} state_e;

  state_e      state_q,  state_d;
  logic [15:0] period_q, period_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0] count_q,  count_d;
  logic [2:0]  status_q, status_d;
  logic        led_q,    led_d;
  logic        pulse_q,  pulse_d;
  logic        tick;
  logic [15:0] count_inc;

  assign tick      = (state_q == ARMED) && (presc_q == PW'(TICK_DIV - 1));
  assign count_inc = count_q + 16'd1;

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    presc_d  = presc_q;
    count_d  = count_q;
    led_d    = led_q;
    pulse_d  = 1'b0;

    case (state_q)
      ARMED: begin
        if (tick) begin
          presc_d = '0;
          count_d = count_inc;
          if (count_inc == period_q) begin
            state_d = EXPIRED;
            led_d   = 1'b1;
            pulse_d = 1'b1;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
        // A refresh on the expiring edge cancels that expiry outright.
        if (bus.wdog_refresh) begin
          state_d = ARMED;
          presc_d = '0;
          count_d = '0;
          led_d   = led_q;
          pulse_d = 1'b0;
        end
      end
      default: presc_d = '0;
    endcase

    if (bus.period_wr) begin
      period_d = bus.period_in;
      presc_d  = '0;
      if (state_q != EXPIRED) begin
        count_d = '0;
        state_d = (bus.period_in == 16'd0) ? IDLE : ARMED;
        led_d   = led_q;
        pulse_d = 1'b0;
      end
    end

    // Clear sees the period written in the same cycle.
    if (bus.timeout_clr && state_q == EXPIRED) begin
      presc_d = '0;
      count_d = '0;
      led_d   = 1'b0;
      state_d = (period_d != 16'd0) ? ARMED : IDLE;
    end

    if (period_q == 16'd0)            status_d = WDOG_DISABLE;
    else if (period_q <= 16'(TH1))    status_d = WDOG_PHASE_ONE;
    else if (period_q <= 16'(TH2))    status_d = WDOG_PHASE_TWO;
    else if (period_q <= 16'(TH3))    status_d = WDOG_PHASE_THREE;
    else                              status_d = WDOG_PHASE_FOUR;
  end

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      state_q  <= IDLE;
      period_q <= '0;
      presc_q  <= '0;
      count_q  <= '0;
      status_q <= WDOG_DISABLE;
      led_q    <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      presc_q  <= presc_d;
      count_q  <= count_d;
      status_q <= status_d;
      led_q    <= led_d;
      pulse_q  <= pulse_d;
    end
  end

  assign bus.wdog_period_status = status_q;
  assign bus.wdog_timeout_led   = led_q;
  assign bus.wdog_timeout_pulse = pulse_q;
  assign bus.wdog_count         = count_q;
endmodule

// File: tb/tb_wdog_period_monitor.sv
// tb/tb_wdog_period_monitor.sv - directed bench for wdog_period_monitor
module tb_wdog_period_monitor;
  localparam int F_STATUS = 0;
  localparam int F_LED    = 1;
  localparam int F_PULSE  = 2;
  localparam int F_COUNT  = 3;
  localparam int F_SAW    = 4;

  typedef struct {
    string       tag;
    int          field;
    logic [15:0] exp;
  } exp_t;

  logic sysclk = 1'b0;
  logic reset  = 1'b0;
  logic saw_pulse = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  wdog_period_monitor_if bus_if ();

  wdog_period_monitor #(.TICK_DIV(4), .TH1(2), .TH2(4), .TH3(8)) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus_if.slave)
  );

  always #5 sysclk = ~sysclk;

  task automatic cyc(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic push(input string tag, input int field, input logic [15:0] v);
    exp_t e;
    e.tag = tag; e.field = field; e.exp = v;
    sb.push_back(e);
  endtask

  function automatic logic [15:0] observe(input int field);
    case (field)
      F_STATUS: return {13'd0, bus_if.wdog_period_status};
      F_LED:    return {15'd0, bus_if.wdog_timeout_led};
      F_PULSE:  return {15'd0, bus_if.wdog_timeout_pulse};
      F_COUNT:  return bus_if.wdog_count;
      default:  return {15'd0, saw_pulse};
    endcase
  endfunction

  task automatic check_all();
    exp_t e;
    logic [15:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = observe(e.field);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic push_reset_state(input string tag);
    push({tag, "_status"}, F_STATUS, 16'd0);
    push({tag, "_led"},    F_LED,    16'd0);
    push({tag, "_pulse"},  F_PULSE,  16'd0);
    push({tag, "_count"},  F_COUNT,  16'd0);
  endtask

  task automatic write_period(input logic [15:0] p);
    bus_if.period_in = p;
    bus_if.period_wr = 1'b1;
    cyc(1);
    bus_if.period_wr = 1'b0;
  endtask

  initial begin
    logic [15:0] periods [5];
    logic [15:0] bands   [5];
    periods = '{16'd0, 16'd2, 16'd3, 16'd5, 16'd9};
    bands   = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4};
    bus_if.period_wr    = 1'b0;
    bus_if.period_in    = 16'd0;
    bus_if.wdog_refresh = 1'b0;
    bus_if.timeout_clr  = 1'b0;

    // Reset
    reset = 1'b0;
    cyc(3);
    push_reset_state("reset");
    check_all();
    reset = 1'b1;
    cyc(50);
    push_reset_state("idle50");
    check_all();

    // Status bands
    for (int i = 0; i < 5; i++) begin
      write_period(periods[i]);
      cyc(1);
      push($sformatf("band_p%0d", periods[i]), F_STATUS, bands[i]);
      check_all();
    end

    // Timeout with period 3
    write_period(16'd3);
    cyc(3);  push("to_n3_count", F_COUNT, 16'd0); check_all();
    cyc(1);  push("to_n4_count", F_COUNT, 16'd1); check_all();
    cyc(4);  push("to_n8_count", F_COUNT, 16'd2); check_all();
    cyc(3);
    push("to_n11_pulse", F_PULSE, 16'd0);
    push("to_n11_led",   F_LED,   16'd0);
    check_all();
    cyc(1);
    push("to_n12_count", F_COUNT, 16'd3);
    push("to_n12_pulse", F_PULSE, 16'd1);
    push("to_n12_led",   F_LED,   16'd1);
    check_all();
    cyc(1);
    push("to_n13_pulse", F_PULSE, 16'd0);
    push("to_n13_led",   F_LED,   16'd1);
    check_all();
    bus_if.wdog_refresh = 1'b1;
    cyc(1);
    bus_if.wdog_refresh = 1'b0;
    cyc(8);
    push("exp_refresh_led",   F_LED,   16'd1);
    push("exp_refresh_count", F_COUNT, 16'd3);
    push("exp_refresh_pulse", F_PULSE, 16'd0);
    check_all();

    // Clear and re-arm
    bus_if.timeout_clr = 1'b1;
    cyc(1);
    bus_if.timeout_clr = 1'b0;
    push("clr_led",   F_LED,   16'd0);
    push("clr_count", F_COUNT, 16'd0);
    check_all();
    cyc(1);  push("clr_c1_led", F_LED, 16'd0); check_all();
    cyc(10); push("clr_c11_pulse", F_PULSE, 16'd0); check_all();
    cyc(1);
    push("clr_c12_pulse", F_PULSE, 16'd1);
    push("clr_c12_led",   F_LED,   16'd1);
    check_all();

    // Refresh keeps alive
    bus_if.timeout_clr = 1'b1;
    cyc(1);
    bus_if.timeout_clr = 1'b0;
    saw_pulse = 1'b0;
    for (int i = 0; i < 200; i++) begin
      bus_if.wdog_refresh = ((i % 11) == 10);
      cyc(1);
      saw_pulse = saw_pulse | bus_if.wdog_timeout_pulse;
    end
    bus_if.wdog_refresh = 1'b0;
    push("alive_no_pulse", F_SAW, 16'd0);
    push("alive_led",      F_LED, 16'd0);
    check_all();

    // Refresh on the expiring edge
    write_period(16'd3);
    cyc(11);
    bus_if.wdog_refresh = 1'b1;
    cyc(1);
    bus_if.wdog_refresh = 1'b0;
    push("race_pulse", F_PULSE, 16'd0);
    push("race_led",   F_LED,   16'd0);
    push("race_count", F_COUNT, 16'd0);
    check_all();
    cyc(11); push("race_r11_led", F_LED, 16'd0); check_all();
    cyc(1);  push("race_r12_pulse", F_PULSE, 16'd1); check_all();

    // Clear together with a zero period write
    bus_if.period_in   = 16'd0;
    bus_if.period_wr   = 1'b1;
    bus_if.timeout_clr = 1'b1;
    cyc(1);
    bus_if.period_wr   = 1'b0;
    bus_if.timeout_clr = 1'b0;
    push("clr0_led",   F_LED,   16'd0);
    push("clr0_count", F_COUNT, 16'd0);
    check_all();
    cyc(1); push("clr0_status", F_STATUS, 16'd0); check_all();
    saw_pulse = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      saw_pulse = saw_pulse | bus_if.wdog_timeout_pulse;
    end
    push("clr0_no_pulse", F_SAW,   16'd0);
    push("clr0_count40",  F_COUNT, 16'd0);
    check_all();

    // Reset mid-count
    write_period(16'd3);
    cyc(8);
    push("mid_count2",  F_COUNT,  16'd2);
    push("mid_status",  F_STATUS, 16'd2);
    check_all();
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    push_reset_state("rst_mid");
    check_all();
    write_period(16'd3);
    cyc(11); push("rst_mid_m11_pulse", F_PULSE, 16'd0); check_all();
    cyc(1);
    push("rst_mid_m12_pulse", F_PULSE, 16'd1);
    push("rst_mid_m12_count", F_COUNT, 16'd3);
    check_all();

    // Reset while expired
    cyc(2);
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    push_reset_state("rst_exp");
    check_all();
    write_period(16'd3);
    cyc(11); push("rst_exp_m11_led", F_LED, 16'd0); check_all();
    cyc(1);
    push("rst_exp_m12_pulse", F_PULSE, 16'd1);
    push("rst_exp_m12_led",   F_LED,   16'd1);
    check_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
